deck_dealer: RTL

Card-deck responder for the blackjack game controller. It answers the controller's shuffle and card-request handshakes. It holds a 52-card deck in internal registers and shuffles it with a Fisher–Yates pass driven by a seeded 6-bit LFSR. It deals cards one at a time in deck order and flags exhaustion.

---
 rtl/deck_dealer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/deck_dealer.sv
// deck_dealer: 52-card deck responder. Fills the deck in rank order, shuffles
// it with a Fisher-Yates pass driven by a 6-bit LFSR (x^6+x^5+1), then deals
// cards one at a time over a 4-phase card handshake, flagging exhaustion.
module deck_dealer (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle_start,
  input  logic [5:0] seed,
  output logic       shuffle_ready,
  input  logic       card_start,
  output logic       card_ready,
  output logic [3:0] card,
  output logic       card_overflow
);

  localparam int unsigned DECK  = 52;
  localparam int unsigned RANKS = 13;
  localparam int unsigned IW    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SHUF,
    ST_SDONE,
    ST_CARD
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_lfsr;
  logic [IW-1:0]   r_k;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_ptr;
  logic [3:0]      r_rank;
  logic [3:0]      r_mem [DECK];

  logic [IW-1:0]   w_j;
  logic [IW-1:0]   w_lfsr_next;
  logic [IW-1:0]   w_seed;
  logic            w_swap;
  logic            w_deck_left;

  // Shuffle datapath: candidate index, LFSR step, seed sanitising
  assign w_j         = r_lfsr - IW'(1);
  assign w_lfsr_next = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
  assign w_seed      = (seed == '0) ? IW'(1) : seed;
  assign w_swap      = (w_j <= r_i);
  assign w_deck_left = (r_ptr < IW'(DECK));

  // Control FSM with registered handshake and card outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_lfsr        <= IW'(1);
      r_k           <= '0;
      r_i           <= '0;
      r_rank        <= 4'd1;
      r_ptr         <= IW'(DECK);
      shuffle_ready <= 1'b1;
      card_ready    <= 1'b0;
      card          <= 4'd0;
      card_overflow <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (shuffle_start) begin
            r_lfsr        <= w_seed;
            r_k           <= '0;
            r_rank        <= 4'd1;
            shuffle_ready <= 1'b0;
            r_state       <= ST_FILL;
          end else if (card_start) begin
            if (w_deck_left) begin
              card  <= r_mem[r_ptr];
              r_ptr <= r_ptr + IW'(1);
            end else begin
              card          <= 4'd0;
              card_overflow <= 1'b1;
            end
            card_ready <= 1'b1;
            r_state    <= ST_CARD;
          end
        end
        ST_FILL: begin
          r_k    <= r_k + IW'(1);
          r_rank <= (r_rank == 4'(RANKS)) ? 4'd1 : r_rank + 4'd1;
          if (r_k == IW'(DECK - 1)) begin
            r_i     <= IW'(DECK - 1);
            r_state <= ST_SHUF;
          end
        end
        ST_SHUF: begin
          r_lfsr <= w_lfsr_next;
          if (w_swap) begin
            r_i <= r_i - IW'(1);
            if (r_i == IW'(1)) begin
              r_state <= ST_SDONE;
            end
          end
        end
        ST_SDONE: begin
          r_ptr         <= '0;
          card_overflow <= 1'b0;
          if (!shuffle_start) begin
            shuffle_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_CARD: begin
          if (!card_start) begin
            card_ready <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Deck storage: rank fill, then in-place swaps; intentionally not reset
  always_ff @(posedge clk) begin
    if (r_state == ST_FILL) begin
      r_mem[r_k] <= r_rank;
    end else if ((r_state == ST_SHUF) && w_swap) begin
      r_mem[r_i] <= r_mem[w_j];
      r_mem[w_j] <= r_mem[r_i];
    end
  end

endmodule
